// File: rtl/epp_bram_port_pkg.sv
// Shared constants for the EPP host port and the BRAM controller.
package epp_bram_port_pkg;

  // EPP register map (low 2 bits of the EPP address register)
  localparam logic [1:0] REG_PTRL = 2'd0;
  localparam logic [1:0] REG_PTRH = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  // Status register bit positions
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DROP = 1;

  // Command byte offsets in the BRAM, shared with the controller
  localparam int unsigned CMD_CTRL  = 0;
  localparam int unsigned CMD_CNFGL = 1;
  localparam int unsigned CMD_CNFGH = 2;

  typedef enum logic [2:0] {
    IDLE,
    A_WR,
    A_RD,
    D_WR,
    D_RD0,
    D_RD1,
    ACK
  } eppState_e;

endpackage

// File: rtl/epp_bram_port_if.sv
// EPP pad bus plus BRAM port A, as seen by the EPP responder.
interface epp_bram_port_if #(parameter int ADDR_W = 12);
  logic              astb;
  logic              dstb;
  logic              pwr;
  logic [7:0]        pdbIn;
  logic [7:0]        pdbOut;
  logic              pdbOe;
  logic              pwait;
  logic [ADDR_W-1:0] bramAddrA;
  logic [7:0]        bramDinA;
  logic [7:0]        bramDoutA;
  logic              bramEnA;
  logic              bramWeA;

  modport slave (
    input  astb, dstb, pwr, pdbIn, bramDoutA,
    output pdbOut, pdbOe, pwait, bramAddrA, bramDinA, bramEnA, bramWeA
  );

  modport master (
    output astb, dstb, pwr, pdbIn, bramDoutA,
    input  pdbOut, pdbOe, pwait, bramAddrA, bramDinA, bramEnA, bramWeA
  );
endinterface

// File: rtl/epp_bram_port_sync.sv
// Multi-stage synchronizer for the asynchronous EPP strobes and direction.
module epp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic astb,
  input  logic dstb,
  input  logic pwr,
  output logic astbS,
  output logic dstbS,
  output logic pwrS
);

  logic [SYNC_STAGES-1:0] aSh, dSh, pSh;

  // Strobes reset to "asserted" so a host cycle in flight at reset cannot arm the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      aSh <= '0;
      dSh <= '0;
      pSh <= '0;
    end else begin
      aSh[0] <= astb;
      dSh[0] <= dstb;
      pSh[0] <= pwr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        aSh[i] <= aSh[i-1];
        dSh[i] <= dSh[i-1];
        pSh[i] <= pSh[i-1];
      end
    end
  end

  assign astbS = aSh[SYNC_STAGES-1];
  assign dstbS = dSh[SYNC_STAGES-1];
  assign pwrS  = pSh[SYNC_STAGES-1];

endmodule

// File: rtl/epp_bram_port.sv
// EPP responder: host access to the command/sample BRAM through port A.
module epp_bram_port
  import epp_bram_port_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2,
  parameter int STB_HOLD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  epp_bram_port_if.slave        bus,
  input  logic                  busy,
  output logic                  dataStb
);

  localparam int CNT_W = (STB_HOLD < 2) ? 1 : $clog2(STB_HOLD + 1);

  logic              astbS, dstbS, pwrS;
  eppState_e         state, nextState;
  logic              armed, cycData, dropped, stbPrev;
  logic [7:0]        addrReg, regData, pdbOutQ;
  logic              pdbOeQ;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  stbCnt;
  logic              isDataReg, strobeHigh;
  logic              pwaitC, enC, weC;
  logic [7:0]        dinC;

  epp_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
    .clk  (clk),
    .rst  (rst),
    .astb (bus.astb),
    .dstb (bus.dstb),
    .pwr  (bus.pwr),
    .astbS(astbS),
    .dstbS(dstbS),
    .pwrS (pwrS)
  );

  assign isDataReg  = (addrReg[1:0] == REG_DATA);
  assign strobeHigh = cycData ? dstbS : astbS;
  assign dataStb    = (stbCnt != '0);

  assign bus.pdbOut    = pdbOutQ;
  assign bus.pdbOe     = pdbOeQ;
  assign bus.pwait     = pwaitC;
  assign bus.bramAddrA = ptr;
  assign bus.bramDinA  = dinC;
  assign bus.bramEnA   = enC;
  assign bus.bramWeA   = weC;

  // Register-map read value for the non-data registers
  always_comb begin
    regData = '0;
    case (addrReg[1:0])
      REG_PTRL: regData = ptr[7:0];
      REG_PTRH: regData = 8'(ptr[ADDR_W-1:8]);
      REG_STAT: begin
        regData[STAT_DROP] = dropped;
        regData[STAT_BUSY] = busy;
      end
      default:  regData = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next state and decoded BRAM/handshake outputs
  always_comb begin
    nextState = state;
    pwaitC    = 1'b0;
    enC       = 1'b0;
    weC       = 1'b0;
    dinC      = '0;
    case (state)
      IDLE: begin
        if (armed) begin
          if (!astbS && dstbS)      nextState = pwrS ? A_RD : A_WR;
          else if (!dstbS && astbS) nextState = pwrS ? D_RD0 : D_WR;
        end
      end
      A_WR, A_RD: nextState = ACK;
      D_WR: begin
        if (isDataReg && !busy) begin
          enC  = 1'b1;
          weC  = 1'b1;
          dinC = bus.pdbIn;
        end
        nextState = ACK;
      end
      D_RD0: begin
        if (isDataReg) begin
          enC       = 1'b1;
          nextState = D_RD1;
        end else begin
          nextState = ACK;
        end
      end
      D_RD1: nextState = ACK;
      ACK: begin
        pwait_blk: begin
          pwaitC = 1'b1;
          // Hold off release until the consumer has seen dataStb fall
          if (strobeHigh && !dataStb && !stbPrev) nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: pointer, address/status registers, read bus and dataStb timer
  always_ff @(posedge clk) begin
    if (rst) begin
      armed   <= 1'b0;
      cycData <= 1'b0;
      dropped <= 1'b0;
      stbPrev <= 1'b0;
      addrReg <= '0;
      pdbOutQ <= '0;
      pdbOeQ  <= 1'b0;
      ptr     <= '0;
      stbCnt  <= '0;
    end else begin
      stbPrev <= dataStb;
      if (stbCnt != '0) stbCnt <= stbCnt - CNT_W'(1);
      if (astbS && dstbS) armed <= 1'b1;
      case (state)
        IDLE:  cycData <= !dstbS;
        A_WR:  addrReg <= bus.pdbIn;
        A_RD: begin
          pdbOutQ <= addrReg;
          pdbOeQ  <= 1'b1;
        end
        D_WR: begin
          case (addrReg[1:0])
            REG_PTRL: ptr[7:0] <= bus.pdbIn;
            REG_PTRH: ptr[ADDR_W-1:8] <= bus.pdbIn[ADDR_W-9:0];
            REG_DATA: begin
              if (busy) begin
                dropped <= 1'b1;
              end else begin
                ptr    <= ptr + ADDR_W'(1);
                stbCnt <= CNT_W'(STB_HOLD);
              end
            end
            default:  dropped <= 1'b0;
          endcase
        end
        D_RD0: begin
          if (!isDataReg) begin
            pdbOutQ <= regData;
            pdbOeQ  <= 1'b1;
          end
        end
        D_RD1: begin
          pdbOutQ <= bus.bramDoutA;
          pdbOeQ  <= 1'b1;
          ptr     <= ptr + ADDR_W'(1);
        end
        ACK: if (nextState == IDLE) pdbOeQ <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_epp_bram_port.sv
// Directed self-checking bench for epp_bram_port with a behavioural BRAM.
module tb_epp_bram_port;

  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic dataStb;

  int vecs = 0;
  int errs = 0;

  logic [7:0] mem [0:4095];
  int wrCount = 0, enCount = 0;
  int stbPulses = 0, stbBadW = 0, stbLen = 0, oeBad = 0;

  epp_bram_port_if #(.ADDR_W(ADDR_W)) bus ();

  epp_bram_port #(.ADDR_W(ADDR_W), .SYNC_STAGES(2), .STB_HOLD(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .dataStb(dataStb)
  );

  always #10 clk = ~clk;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  end

  // Port A memory, read-first, 1-cycle read latency
  always @(posedge clk) begin
    if (bus.bramEnA === 1'b1) begin
      enCount++;
      if (bus.bramWeA === 1'b1) begin
        mem[bus.bramAddrA] <= bus.bramDinA;
        wrCount++;
      end
      bus.bramDoutA <= mem[bus.bramAddrA];
    end
  end

  // dataStb pulse widths and pdbOe outside the acknowledge phase
  always @(negedge clk) begin
    if (dataStb === 1'b1) stbLen++;
    else if (stbLen != 0) begin
      stbPulses++;
      if (stbLen != 2) stbBadW++;
      stbLen = 0;
    end
    if (bus.pdbOe === 1'b1 && bus.pwait !== 1'b1) oeBad++;
  end

  task automatic eppCycle(input bit isData, input bit rd, input logic [7:0] wdata,
                          output logic [7:0] rdata, output logic oe, output int lat);
    int n;
    @(negedge clk);
    bus.pwr = rd;
    bus.pdbIn = wdata;
    if (isData) bus.dstb = 1'b0; else bus.astb = 1'b0;
    n = 0;
    while (bus.pwait !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    lat = n;
    if (bus.pwait !== 1'b1) begin
      vecs++; errs++;
      $display("FAIL handshake_ack: pwait=%b after %0d cycles, required 1", bus.pwait, n);
    end
    rdata = bus.pdbOut;
    oe = bus.pdbOe;
    @(negedge clk);
    bus.astb = 1'b1;
    bus.dstb = 1'b1;
    n = 0;
    while (bus.pwait !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    if (bus.pwait !== 1'b0) begin
      vecs++; errs++;
      $display("FAIL handshake_release: pwait=%b after %0d cycles, required 0", bus.pwait, n);
    end
    bus.pwr = 1'b0;
  endtask

  task automatic addrWrite(input logic [7:0] a);
    logic [7:0] d; logic oe; int l;
    eppCycle(1'b0, 1'b0, a, d, oe, l);
  endtask

  task automatic addrRead(output logic [7:0] d);
    logic oe; int l;
    eppCycle(1'b0, 1'b1, 8'h00, d, oe, l);
  endtask

  task automatic dataWrite(input logic [7:0] v, output int lat);
    logic [7:0] d; logic oe;
    eppCycle(1'b1, 1'b0, v, d, oe, lat);
  endtask

  task automatic dataRead(output logic [7:0] d, output logic oe, output int lat);
    eppCycle(1'b1, 1'b1, 8'h00, d, oe, lat);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    vecs++;
    if ({bus.pdbOut, bus.pdbOe, bus.pwait, bus.bramEnA, bus.bramWeA, bus.bramAddrA,
         bus.bramDinA, dataStb} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: pdbOut=%h pdbOe=%b pwait=%b en=%b we=%b addr=%h din=%h stb=%b, required all 0",
               bus.pdbOut, bus.pdbOe, bus.pwait, bus.bramEnA, bus.bramWeA, bus.bramAddrA, bus.bramDinA, dataStb);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    addrRead(d);
    vecs++;
    if (d !== 8'h00) begin errs++; $display("FAIL reset_addr_reg: got %h, required 00", d); end
  endtask

  task automatic test_writes();
    int lat, w0, p0; logic [7:0] d; logic oe;
    w0 = wrCount; p0 = stbPulses;
    addrWrite(8'h00); dataWrite(8'h00, lat);
    addrWrite(8'h02);
    dataWrite(8'h11, lat);
    vecs++;
    if (lat !== 4) begin errs++; $display("FAIL write_latency: got %0d, required 4", lat); end
    dataWrite(8'h34, lat);
    dataWrite(8'h12, lat);
    vecs++;
    if ({mem[0], mem[1], mem[2]} !== 24'h113412) begin
      errs++; $display("FAIL write_data: got %h %h %h, required 11 34 12", mem[0], mem[1], mem[2]);
    end
    vecs++;
    if (wrCount - w0 !== 3) begin errs++; $display("FAIL write_count: got %0d, required 3", wrCount - w0); end
    vecs++;
    if (stbPulses - p0 !== 3) begin errs++; $display("FAIL stb_pulses: got %0d, required 3", stbPulses - p0); end
    vecs++;
    if (stbBadW !== 0) begin errs++; $display("FAIL stb_width: %0d pulses not 2 cycles, required 0", stbBadW); end
    addrWrite(8'h00); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h03) begin errs++; $display("FAIL ptrL_after_writes: got %h, required 03", d); end
    vecs++;
    if (lat !== 4) begin errs++; $display("FAIL reg_read_latency: got %0d, required 4", lat); end
    addrWrite(8'h01); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h00) begin errs++; $display("FAIL ptrH_after_writes: got %h, required 00", d); end
  endtask

  task automatic test_busy();
    int lat, w0, p0; logic [7:0] d; logic oe;
    mem[3] = 8'hEE;
    w0 = wrCount; p0 = stbPulses;
    busy = 1'b1;
    addrWrite(8'h02);
    dataWrite(8'h55, lat);
    repeat (4) @(negedge clk);
    vecs++;
    if (mem[3] !== 8'hEE || wrCount !== w0) begin
      errs++; $display("FAIL busy_no_write: mem[3]=%h writes=%0d, required EE 0", mem[3], wrCount - w0);
    end
    vecs++;
    if (stbPulses !== p0) begin errs++; $display("FAIL busy_no_stb: got %0d pulses, required 0", stbPulses - p0); end
    addrWrite(8'h03); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h03) begin errs++; $display("FAIL status_dropped: got %h, required 03", d); end
    dataWrite(8'h00, lat);
    dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h01) begin errs++; $display("FAIL status_cleared: got %h, required 01", d); end
    busy = 1'b0;
    addrWrite(8'h00); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h03) begin errs++; $display("FAIL busy_ptr_unchanged: got %h, required 03", d); end
  endtask

  task automatic test_data_read();
    int lat; logic [7:0] d; logic oe;
    mem[12'h100] = 8'hA5; mem[12'h101] = 8'h5A;
    addrWrite(8'h00); dataWrite(8'h00, lat);
    addrWrite(8'h01); dataWrite(8'h01, lat);
    addrWrite(8'h02);
    dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'hA5 || oe !== 1'b1) begin errs++; $display("FAIL data_read0: got %h oe=%b, required A5 oe=1", d, oe); end
    vecs++;
    if (lat !== 5) begin errs++; $display("FAIL data_read_latency: got %0d, required 5", lat); end
    dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h5A) begin errs++; $display("FAIL data_read1: got %h, required 5A", d); end
    vecs++;
    if (oeBad !== 0) begin errs++; $display("FAIL oe_outside_ack: %0d cycles, required 0", oeBad); end
    addrWrite(8'h00); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h02) begin errs++; $display("FAIL read_ptrL: got %h, required 02", d); end
    addrWrite(8'h01); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h01) begin errs++; $display("FAIL read_ptrH: got %h, required 01", d); end
  endtask

  task automatic test_wrap();
    int lat; logic [7:0] d; logic oe;
    addrWrite(8'h00); dataWrite(8'hFF, lat);
    addrWrite(8'h01); dataWrite(8'h0F, lat);
    addrWrite(8'h02); dataWrite(8'h77, lat);
    vecs++;
    if (mem[12'hFFF] !== 8'h77) begin errs++; $display("FAIL wrap_write: got %h, required 77", mem[12'hFFF]); end
    addrWrite(8'h00); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h00) begin errs++; $display("FAIL wrap_ptrL: got %h, required 00", d); end
    addrWrite(8'h01); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h00) begin errs++; $display("FAIL wrap_ptrH: got %h, required 00", d); end
    addrWrite(8'h00); dataWrite(8'hFF, lat);
    addrWrite(8'h01); dataWrite(8'h0F, lat);
    addrWrite(8'h02); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h77) begin errs++; $display("FAIL wrap_read: got %h, required 77", d); end
    addrWrite(8'h00); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h00) begin errs++; $display("FAIL wrap_read_ptrL: got %h, required 00", d); end
  endtask

  task automatic test_reset_mid_write();
    int lat, w0; bit sawWait; logic [7:0] d; logic oe;
    mem[12'h010] = 8'h3C;
    addrWrite(8'h00); dataWrite(8'h10, lat);
    addrWrite(8'h01); dataWrite(8'h00, lat);
    addrWrite(8'h02);
    w0 = wrCount;
    @(negedge clk);
    bus.pwr = 1'b0; bus.pdbIn = 8'h99; bus.dstb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if ({bus.pdbOut, bus.pdbOe, bus.pwait, bus.bramEnA, bus.bramWeA, bus.bramAddrA,
         bus.bramDinA, dataStb} !== '0) begin
      errs++;
      $display("FAIL midreset_outputs: pdbOut=%h pdbOe=%b pwait=%b en=%b we=%b addr=%h din=%h stb=%b, required all 0",
               bus.pdbOut, bus.pdbOe, bus.pwait, bus.bramEnA, bus.bramWeA, bus.bramAddrA, bus.bramDinA, dataStb);
    end
    rst = 1'b0;
    sawWait = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.pwait === 1'b1) sawWait = 1'b1; end
    bus.dstb = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.pwait === 1'b1) sawWait = 1'b1; end
    vecs++;
    if (sawWait || wrCount !== w0 || mem[12'h010] !== 8'h3C) begin
      errs++;
      $display("FAIL midreset_no_cycle: pwaitSeen=%b writes=%0d mem[010]=%h, required 0 0 3C", sawWait, wrCount - w0, mem[12'h010]);
    end
    addrWrite(8'h02); dataWrite(8'h66, lat);
    vecs++;
    if (mem[0] !== 8'h66 || wrCount !== w0 + 1) begin
      errs++; $display("FAIL midreset_fresh_write: mem[0]=%h writes=%0d, required 66 1", mem[0], wrCount - w0);
    end
    addrWrite(8'h00); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h01) begin errs++; $display("FAIL midreset_ptr: got %h, required 01", d); end
  endtask

  task automatic test_both_low();
    int e0, lat; bit sawWait; logic [7:0] d; logic oe;
    e0 = enCount;
    sawWait = 1'b0;
    @(negedge clk);
    bus.pwr = 1'b0; bus.astb = 1'b0; bus.dstb = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.pwait === 1'b1) sawWait = 1'b1; end
    bus.astb = 1'b1; bus.dstb = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.pwait === 1'b1) sawWait = 1'b1; end
    vecs++;
    if (sawWait || enCount !== e0) begin
      errs++; $display("FAIL both_low: pwaitSeen=%b bramAccesses=%0d, required 0 0", sawWait, enCount - e0);
    end
    addrWrite(8'h03); dataRead(d, oe, lat);
    vecs++;
    if (d !== 8'h00) begin errs++; $display("FAIL both_low_status: got %h, required 00", d); end
  endtask

  initial begin
    bus.astb = 1'b1; bus.dstb = 1'b1; bus.pwr = 1'b0; bus.pdbIn = 8'h00;
    busy = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_writes();
    test_busy();
    test_data_read();
    test_wrap();
    test_reset_mid_write();
    test_both_low();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/epp_bram_port.md
Name: epp_bram_port

Overview:
- EPP responder, host-facing side of the command/sample BRAM.
- Decodes host EPP address/data cycles and writes command bytes (ctrl, cnfg L, cnfg H) into BRAM port A. Emits the dataStb pulse counted by the controller on port B.
- Serves host reads of ADC sample data from port A and honours the controller's busy flag so host writes cannot collide with port-B reads.

Parameters:
- ADDR_W, 12, BRAM address width; pointer wraps modulo 2^ADDR_W.
- SYNC_STAGES, 2, flip-flop stages on astb/dstb/pwr before use.
- STB_HOLD, 2, clk cycles dataStb stays high per committed write (consumer needs ≥2 for its edge detector).

Ports:
- clk  in  1  50 MHz system clock, also clocks BRAM port A.
- rst  in  1  synchronous, active-high reset.
- astb  in  1  EPP address strobe, active low, asynchronous.
- dstb  in  1  EPP data strobe, active low, asynchronous.
- pwr  in  1  EPP direction: 0 = host write, 1 = host read.
- pdbIn  in  8  EPP data bus from the pad.
- pdbOut  out  8  EPP data bus to the pad.
- pdbOe  out  1  pad output enable, 1 = drive pdbOut.
- pwait  out  1  EPP wait/acknowledge.
- bramAddrA  out  ADDR_W  BRAM port A address.
- bramDinA  out  8  BRAM port A write data.
- bramDoutA  in  8  BRAM port A read data, valid 1 clk after bramEnA.
- bramEnA  out  1  port A enable.
- bramWeA  out  1  port A write enable.
- busy  in  1  controller busy; host data writes must not reach BRAM while high.
- dataStb  out  1  pulse per committed data-port write.

Behaviour:
- Reset values:
  - pdbOut=0, pdbOe=0, pwait=0, bramEnA=0, bramWeA=0, bramAddrA=0, bramDinA=0, dataStb=0.
  - Pointer=0, epp address register=0, dropped=0, armed=0, FSM=IDLE.
- armed:
  - Set once synced astb and dstb are both high.
  - No cycle starts while armed=0, so a reset in the middle of a cycle never completes a half cycle.
- Register map (epp address register, low 2 bits):
  - 0 = pointer[7:0] R/W.
  - 1 = pointer[ADDR_W-1:8] R/W; unused bits read 0.
  - 2 = data port R/W; pointer auto-increments after each access.
  - 3 = status. Read gives {6'b0, dropped, busy}. Any write clears dropped.
- FSM states: IDLE, A_WR, A_RD, D_WR, D_RD0, D_RD1, ACK.
- IDLE transitions (armed, synced strobes only):
  - astb low and dstb high: A_WR if pwr=0, else A_RD.
  - dstb low and astb high: D_WR if pwr=0, else D_RD0.
  - Both low: protocol error; stay in IDLE.
- A_WR: latch pdbIn into the address register; go to ACK.
- A_RD: pdbOut = address register, pdbOe=1; go to ACK.
- D_WR, data port, busy=0:
  - bramWeA=bramEnA=1 for exactly 1 cycle; address = pointer, data = pdbIn.
  - Pointer +1; dataStb high for STB_HOLD cycles.
- D_WR, data port, busy=1:
  - No BRAM write, no dataStb, pointer unchanged, dropped=1.
  - The host is still acknowledged.
- D_WR to regs 0, 1 or 3: register update only; 1 cycle.
- D_RD0: bramEnA=1 at pointer. D_RD1: pdbOut=bramDoutA, pdbOe=1, pointer +1.
- D_RD for regs 0, 1, 3: value driven in D_RD0, which then skips to ACK.
- ACK:
  - pwait=1; pdbOe held for reads.
  - Stay until the active strobe is synced high AND dataStb is low and has been low ≥1 cycle.
  - Then pwait=0, pdbOe=0, go to IDLE.
- Latency, synced strobe low to pwait high:
  - Write: 2 cycles.
  - Register read: 2 cycles.
  - Data read: 3 cycles.
  - Add SYNC_STAGES for the pad-level delay.
- Pointer wraps from 2^ADDR_W-1 to 0, on both read and write.
- busy sampled in D_WR only. A rise of busy during ACK does not undo a write already committed.
- pdbOe is never 1 while pwr=0 is latched for the current cycle.

Decomposition:
- Shared package contents:
  - Register index constants REG_PTRL=0, REG_PTRH=1, REG_DATA=2, REG_STAT=3.
  - Status bit positions.
  - FSM state encoding.
  - BRAM command offsets CMD_CTRL=0, CMD_CNFGL=1, CMD_CNFGH=2 (shared with the controller).
- Sub-module: epp_sync, an SYNC_STAGES-deep synchronizer for astb/dstb/pwr.

Test Plan:
- Addr write 0x00, data 0x00; addr write 0x02, data writes 0x11, 0x34, 0x12 → BRAM[0..2]=11,34,12; three dataStb pulses each exactly 2 cycles high; pointer=3.
- busy=1, data write 0x55 at pointer 3 → BRAM[3] unchanged, no dataStb, pwait still handshakes; status read returns 0x03; write to reg 3 → status read 0x01.
- Preload BRAM[0x100]=0xA5, [0x101]=0x5A; set pointer 0x100; two data reads → host gets A5, 5A; pdbOe only during ACK; pointer=0x102.
- Pointer 0xFFF, data write 0x77 → BRAM[0xFFF]=77, pointer reads back 0x000 (ptrH=0, ptrL=0).
- Assert rst while dstb low mid-write → all outputs at reset values; no BRAM write until dstb returns high and a fresh cycle starts.
- astb and dstb driven low together → no pwait, no BRAM access, FSM stays IDLE.
